// File: rtl/instr_control_unit.sv
// ============================================================================
// instr_control_unit : hardwired fetch/decode/execute sequencer for the 5-bit ISA
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_control_unit #(
    parameter int         OPW     = 5,
    parameter logic [4:0] ALU_ADD = 5'b00011
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        BAout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        Zin,
    output logic        MDRin,
    output logic        MARin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IRin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [15:0] R0_15_enable,
    output logic [4:0]  alu_op,
    output logic        Clear,
    output logic        Run
);

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
    localparam logic [OPW-1:0] OP_BR   = OPW'(19);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(21);
    localparam logic [OPW-1:0] OP_JR   = OPW'(20);
    localparam logic [OPW-1:0] OP_IN   = OPW'(22);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    localparam logic [4:0] ALU_AND = 5'd5;
    localparam logic [4:0] ALU_OR  = 5'd6;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    state_t         state;
    logic [OPW-1:0] op;
    logic           unused_ir_bits;

    logic is_alu, is_imm, is_ld, is_ldi, is_st, is_addr, is_muldiv, is_negnot;
    logic is_br, is_jal, is_halt, is_multi;

    assign op             = IR[31 -: OPW];
    assign unused_ir_bits = &{1'b0, IR[31-OPW:0]};

    assign is_alu    = (op >= OP_ADD) && (op <= OP_SHL);
    assign is_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
    assign is_ld     = (op == OP_LD);
    assign is_ldi    = (op == OP_LDI);
    assign is_st     = (op == OP_ST);
    assign is_addr   = is_ld || is_ldi || is_st;
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_negnot = (op == OP_NEG) || (op == OP_NOT);
    assign is_br     = (op == OP_BR);
    assign is_jal    = (op == OP_JAL);
    assign is_halt   = (op == OP_HALT);
    // Everything else (jr, in, out, mfhi/mflo, nop, undefined) finishes in T3.
    assign is_multi  = is_alu || is_imm || is_addr || is_muldiv || is_negnot || is_br || is_jal;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= Stop ? S_HALT : S_T3;
                S_T3:    state <= is_halt ? S_HALT : (is_multi ? S_T4 : S_T0);
                S_T4:    state <= (is_negnot || is_jal) ? S_T0 : S_T5;
                S_T5:    state <= (is_alu || is_imm || is_ldi) ? S_T0 : S_T6;
                S_T6:    state <= (is_ld || is_st) ? S_T7 : S_T0;
                S_T7:    state <= S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    // IR is loaded on the edge leaving T2, so execute strobes must decode it combinationally.
    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout} = '0;
        {PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin}       = '0;
        {Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write}                          = '0;
        R0_15_enable = 16'h0000;
        alu_op       = 5'd0;
        Clear        = (state == S_RESET);
        Run          = (state != S_RESET) && (state != S_HALT);

        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_alu || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_addr) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_negnot) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = 5'(op);
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (op == OP_JR) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (is_jal) begin
                    PCout = 1'b1; R0_15_enable = 16'h8000;
                end else if (op == OP_IN) begin
                    InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_OUT) begin
                    Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
                end else if (op == OP_MFHI) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op == OP_MFLO) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu || is_muldiv) begin
                    Rout = 1'b1; Zin = 1'b1; alu_op = 5'(op);
                    Grc  = is_alu;
                    Grb  = is_muldiv;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1;
                    alu_op = (op == OP_ADDI) ? ALU_ADD : ((op == OP_ANDI) ? ALU_AND : ALU_OR);
                end else if (is_addr) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
                end else if (is_negnot) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (is_jal) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu || is_imm || is_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_muldiv) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end else if (is_br && CON_FF) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
